// File: rtl/ctrl_rx.sv
// Serial command deserializer: recovers start/data/stop framed words from the
// sys_ctrl line(s) and presents them on a valid/ready interface.
module ctrl_rx #(
    parameter int unsigned LENGTH = 32,
    parameter int unsigned LINES  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LINES-1:0]  d,
    output logic [LENGTH-1:0] data_out,
    output logic              valid,
    input  logic              ready,
    output logic              busy,
    output logic              err_frame,
    output logic              err_overflow
);

    localparam int unsigned NumCycles = LENGTH / LINES;
    localparam int unsigned BitCntW   = $clog2(NumCycles + 1);
    localparam int unsigned SyncCntW  = $clog2(NumCycles + 3);
    localparam logic [SyncCntW-1:0] SyncMax  = SyncCntW'(NumCycles + 2);
    localparam logic [BitCntW-1:0]  LastData = BitCntW'(NumCycles - 1);

    typedef enum logic [1:0] {StSync, StIdle, StData, StStop} state_e;

    state_e              state_q, state_d;
    logic [LINES-1:0]    d_q;
    logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [SyncCntW-1:0] sync_cnt_q, sync_cnt_d;
    logic [LENGTH-1:0]   shift_q, shift_d;
    logic [LENGTH-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                err_frame_q, err_frame_d;
    logic                err_overflow_q, err_overflow_d;
    logic                word_done;
    logic                frame_bad;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        sync_cnt_d = sync_cnt_q;
        shift_d    = shift_q;
        word_done  = 1'b0;
        frame_bad  = 1'b0;
        unique case (state_q)
            StSync: begin
                if (d_q[0]) begin
                    sync_cnt_d = '0;
                end else begin
                    // Saturating count of consecutive idle cycles.
                    sync_cnt_d = (sync_cnt_q == SyncMax) ? sync_cnt_q
                                                         : sync_cnt_q + SyncCntW'(1);
                    if (sync_cnt_d == SyncMax) begin
                        state_d    = StIdle;
                        sync_cnt_d = '0;
                    end
                end
            end
            StIdle: begin
                if (d_q[0]) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                shift_d   = (shift_q << LINES) | LENGTH'(d_q);
                bit_cnt_d = bit_cnt_q + BitCntW'(1);
                if (bit_cnt_q == LastData) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (!d_q[0]) begin
                    word_done = 1'b1;
                    state_d   = StIdle;
                end else begin
                    frame_bad = 1'b1;
                    state_d   = StSync;
                end
            end
            default: state_d = StSync;
        endcase
    end

    // A finished word is dropped, not queued, when the consumer is stalled.
    always_comb begin
        data_d         = data_q;
        valid_d        = valid_q;
        err_frame_d    = frame_bad;
        err_overflow_d = 1'b0;
        if (word_done) begin
            if (!valid_q || ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                err_overflow_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        busy_d = (state_d == StData) || (state_d == StStop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StSync;
            d_q            <= '0;
            bit_cnt_q      <= '0;
            sync_cnt_q     <= '0;
            shift_q        <= '0;
            data_q         <= '0;
            valid_q        <= 1'b0;
            busy_q         <= 1'b0;
            err_frame_q    <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            d_q            <= d;
            bit_cnt_q      <= bit_cnt_d;
            sync_cnt_q     <= sync_cnt_d;
            shift_q        <= shift_d;
            data_q         <= data_d;
            valid_q        <= valid_d;
            busy_q         <= busy_d;
            err_frame_q    <= err_frame_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign data_out     = data_q;
    assign valid        = valid_q;
    assign busy         = busy_q;
    assign err_frame    = err_frame_q;
    assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_ctrl_rx.sv
// Bench for ctrl_rx: one 1-line and one 4-line receiver, directed frames plus
// random frames, checked every cycle against a frame-level reference model.
module tb_ctrl_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        d1;
    logic [3:0]  d4;
    logic [1:0]  rdy;
    logic [31:0] dout0, dout1;
    logic        vld0, vld1, busy0, busy1, ef0, ef1, eo0, eo1;

    always #5 clk = ~clk;

    ctrl_rx #(.LENGTH(32), .LINES(1)) u_rx1 (
        .clk(clk), .rst(rst), .d(d1), .data_out(dout0), .valid(vld0), .ready(rdy[0]),
        .busy(busy0), .err_frame(ef0), .err_overflow(eo0)
    );

    ctrl_rx #(.LENGTH(32), .LINES(4)) u_rx4 (
        .clk(clk), .rst(rst), .d(d4), .data_out(dout1), .valid(vld1), .ready(rdy[1]),
        .busy(busy1), .err_frame(ef1), .err_overflow(eo1)
    );

    // Model: each in-sync frame is an event at the cycle its stop bit is judged.
    typedef struct {int cyc; bit bad; logic [31:0] w;} ev_t;
    typedef struct {int lo; int hi;} win_t;

    ev_t         evq[2][$];
    win_t        bwq[2][$];
    logic [31:0] m_data[2];
    bit          m_valid[2], m_ef[2], m_eo[2];
    int          rmode[2];
    int          cyc, npass, nfail, ntotal;

    function automatic int ncyc(int i);
        return (i == 0) ? 32 : 8;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            logic [31:0] od;
            logic        ov, ob, oe, oo;
            bit          be;
            if (i == 0) begin
                od = dout0; ov = vld0; ob = busy0; oe = ef0; oo = eo0;
            end else begin
                od = dout1; ov = vld1; ob = busy1; oe = ef1; oo = eo1;
            end
            while (bwq[i].size() > 0 && bwq[i][0].hi < cyc) void'(bwq[i].pop_front());
            be = (bwq[i].size() > 0) && (bwq[i][0].lo <= cyc);
            chk($sformatf("valid%0d", i), 32'(ov), 32'(m_valid[i]));
            chk($sformatf("data_out%0d", i), od, m_data[i]);
            chk($sformatf("busy%0d", i), 32'(ob), 32'(be));
            chk($sformatf("err_frame%0d", i), 32'(oe), 32'(m_ef[i]));
            chk($sformatf("err_overflow%0d", i), 32'(oo), 32'(m_eo[i]));
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit          done;
            logic [31:0] w;
            ev_t         e;
            if (rst) continue;
            m_ef[i] = 1'b0;
            m_eo[i] = 1'b0;
            done    = 1'b0;
            w       = '0;
            if (evq[i].size() > 0 && evq[i][0].cyc == cyc) begin
                e = evq[i].pop_front();
                if (e.bad) m_ef[i] = 1'b1;
                else begin
                    done = 1'b1;
                    w    = e.w;
                end
            end
            if (done) begin
                if (!m_valid[i] || rdy[i]) begin
                    m_data[i]  = w;
                    m_valid[i] = 1'b1;
                end else begin
                    m_eo[i] = 1'b1;
                end
            end else if (m_valid[i] && rdy[i]) begin
                m_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check_all();
        for (int i = 0; i < 2; i++) begin
            if (rmode[i] == 0) rdy[i] = 1'b1;
            else if (rmode[i] == 1) rdy[i] = 1'b0;
            else rdy[i] = 1'($urandom & 1);
        end
    endtask

    task automatic idle(int n);
        repeat (n) tick();
    endtask

    task automatic reset_pulse();
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            evq[i].delete();
            bwq[i].delete();
            m_valid[i] = 1'b0;
            m_data[i]  = '0;
            m_ef[i]    = 1'b0;
            m_eo[i]    = 1'b0;
        end
        check_all();
        #1 rst = 1'b0;
    endtask

    // sync=0 marks a frame the receiver is expected to ignore.
    task automatic send(int i, logic [31:0] w, bit bad, bit sync, int rst_at);
        int n;
        int s;
        n = ncyc(i);
        s = cyc;
        if (sync) begin
            evq[i].push_back('{cyc: s + n + 2, bad: bad, w: w});
            bwq[i].push_back('{lo: s + 2, hi: s + n + 2});
        end
        for (int k = 0; k <= n + 1; k++) begin
            logic [31:0] r;
            logic [3:0]  v;
            r = $urandom;
            if (k == 0) v = {r[3:1], 1'b1};
            else if (k == n + 1) v = {r[3:1], bad};
            else if (i == 0) v = {3'b000, w[32-k]};
            else v = w[35-4*k -: 4];
            if (i == 0) d1 = v[0];
            else d4 = v;
            if (k == rst_at) reset_pulse();
            tick();
        end
        if (i == 0) d1 = 1'b0;
        else d4 = '0;
    endtask

    initial begin
        logic [31:0] w;
        bit          bad;
        int          gap;
        rst = 1'b1; d1 = 1'b0; d4 = '0; rdy = 2'b11;
        cyc = 0; npass = 0; nfail = 0; ntotal = 0;
        for (int i = 0; i < 2; i++) begin
            rmode[i] = 0; m_data[i] = '0; m_valid[i] = 1'b0; m_ef[i] = 1'b0; m_eo[i] = 1'b0;
        end
        idle(3);
        rst = 1'b0;
        idle(40);

        send(0, 32'hF000_0000, 1'b0, 1'b1, -1);
        idle(5);
        send(0, 32'hF0B4_0411, 1'b0, 1'b1, -1);
        send(0, 32'hF0B4_0211, 1'b0, 1'b1, -1);
        idle(5);

        rmode[0] = 1; rdy[0] = 1'b0;
        send(0, 32'hF090_0000, 1'b0, 1'b1, -1);
        idle(3);
        send(0, 32'hF090_0001, 1'b0, 1'b1, -1);
        idle(3);
        rmode[0] = 0; rdy[0] = 1'b1;
        idle(3);

        send(0, 32'hF0A0_0100, 1'b1, 1'b1, -1);
        idle(5);
        send(0, 32'hF0A0_0100, 1'b0, 1'b0, -1);
        idle(40);
        send(0, 32'hF0A0_0100, 1'b0, 1'b1, -1);
        idle(3);

        send(0, 32'hF0B4_0311, 1'b0, 1'b1, 15);
        idle(40);
        send(0, 32'hF0B4_0311, 1'b0, 1'b1, -1);
        idle(3);

        send(1, 32'h1234_5678, 1'b0, 1'b1, -1);
        idle(3);

        for (int i = 0; i < 2; i++) begin
            rmode[i] = 2;
            repeat (15) begin
                w   = $urandom;
                bad = ($urandom_range(0, 5) == 0);
                if (bad) gap = ncyc(i) + 4 + $urandom_range(0, 4);
                else if ($urandom_range(0, 2) == 0) gap = 0;
                else gap = ncyc(i) + 2 + $urandom_range(0, 5);
                send(i, w, bad, 1'b1, -1);
                idle(gap);
            end
            rmode[i] = 0; rdy[i] = 1'b1;
            idle(5);
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
